// File: rtl/uart_baud_gen.sv
// Baud-rate tick generator: programmable integer divisor with a fractional
// accumulator, plus an oversampling phase counter that produces sample,
// mid-bit and bit ticks as single-cycle enables for the UART datapaths.
module uart_baud_gen #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned FRAC_W      = 4,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DEFAULT_DIV = 3,
  localparam int unsigned PH_W       = $clog2(OVERSAMPLE),
  localparam int unsigned CW1        = CNT_W + 1
) (
  input  logic              clk,
  input  logic              async_nreset,
  input  logic              enable,
  input  logic              clear,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              sample_tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic [PH_W-1:0]   phase
);

  // Counting state
  logic [CW1-1:0]    cnt_q, cnt_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              ext_q, ext_d;

  // Active and pending divisor
  logic [CNT_W-1:0]  div_q, div_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [CNT_W-1:0]  pend_div_q, pend_div_d;
  logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
  logic              pend_q, pend_d;

  logic [CW1-1:0]    period_end;
  logic [FRAC_W:0]   acc_sum;
  logic              run;
  logic              tick;

  // Counter is one bit wider than the divisor so D = max with ext = 1 fits.
  assign period_end = {1'b0, div_q} + {{CNT_W{1'b0}}, ext_q};
  assign run        = enable & ~clear;
  assign tick       = run & (cnt_q == period_end);
  assign acc_sum    = {1'b0, acc_q} + {1'b0, frac_q};

  // Next-state for counter, phase and fractional accumulator
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    acc_d   = acc_q;
    ext_d   = ext_q;
    if (clear) begin
      cnt_d   = '0;
      phase_d = '0;
      acc_d   = '0;
      ext_d   = 1'b0;
    end else if (enable) begin
      if (tick) begin
        cnt_d   = '0;
        phase_d = phase_q + PH_W'(1);
        // Carry out of the accumulator stretches the following period by one.
        acc_d   = acc_sum[FRAC_W-1:0];
        ext_d   = acc_sum[FRAC_W];
      end else begin
        cnt_d   = cnt_q + CW1'(1);
      end
    end
  end

  // Next-state for active/pending divisor: changes land only at a period
  // boundary, while idle, or under clear, so cnt never overshoots while running.
  always_comb begin
    div_d       = div_q;
    frac_d      = frac_q;
    pend_div_d  = pend_div_q;
    pend_frac_d = pend_frac_q;
    pend_d      = pend_q;
    if (div_load && (!enable || clear || tick)) begin
      div_d  = div_int;
      frac_d = div_frac;
      pend_d = 1'b0;
    end else if (div_load) begin
      pend_div_d  = div_int;
      pend_frac_d = div_frac;
      pend_d      = 1'b1;
    end else if (pend_q && (clear || tick)) begin
      div_d  = pend_div_q;
      frac_d = pend_frac_q;
      pend_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      cnt_q       <= '0;
      phase_q     <= '0;
      acc_q       <= '0;
      ext_q       <= 1'b0;
      div_q       <= CNT_W'(DEFAULT_DIV);
      frac_q      <= '0;
      pend_div_q  <= '0;
      pend_frac_q <= '0;
      pend_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      ext_q       <= ext_d;
      div_q       <= div_d;
      frac_q      <= frac_d;
      pend_div_q  <= pend_div_d;
      pend_frac_q <= pend_frac_d;
      pend_q      <= pend_d;
    end
  end

  // Tick decodes straight from registered state, no added latency
  always_comb begin
    sample_tick = tick;
    mid_tick    = tick & (phase_q == PH_W'(OVERSAMPLE / 2 - 1));
    bit_tick    = tick & (phase_q == PH_W'(OVERSAMPLE - 1));
    phase       = phase_q;
  end

  a_mid_bit_exclusive : assert property (@(posedge clk) disable iff (!async_nreset)
    !(mid_tick && bit_tick));
  a_sub_ticks_on_sample : assert property (@(posedge clk) disable iff (!async_nreset)
    (mid_tick || bit_tick) |-> sample_tick);

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: directed period/phase scenarios plus randomized
// enable/clear/load traffic, all checked cycle by cycle against a model that
// tracks elapsed cycles against period length and counts ticks.
module tb_uart_baud_gen;

  localparam int unsigned CNT_W       = 16;
  localparam int unsigned FRAC_W      = 4;
  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned DEFAULT_DIV = 3;
  localparam int unsigned PH_W        = $clog2(OVERSAMPLE);
  localparam int unsigned CNT_MOD     = 1 << (CNT_W + 1);
  localparam int unsigned FRAC_MOD    = 1 << FRAC_W;

  logic              clk = 1'b0;
  logic              async_nreset = 1'b1;
  logic              enable = 1'b0;
  logic              clear = 1'b0;
  logic [CNT_W-1:0]  div_int = '0;
  logic [FRAC_W-1:0] div_frac = '0;
  logic              div_load = 1'b0;
  logic              sample_tick;
  logic              mid_tick;
  logic              bit_tick;
  logic [PH_W-1:0]   phase;

  uart_baud_gen #(
    .CNT_W      (CNT_W),
    .FRAC_W     (FRAC_W),
    .OVERSAMPLE (OVERSAMPLE),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk         (clk),
    .async_nreset(async_nreset),
    .enable      (enable),
    .clear       (clear),
    .div_int     (div_int),
    .div_frac    (div_frac),
    .div_load    (div_load),
    .sample_tick (sample_tick),
    .mid_tick    (mid_tick),
    .bit_tick    (bit_tick),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model: cycles elapsed in the current period, the stretch bit,
  // fractional residue, and a running tick count since reset/clear.
  int unsigned m_pos, m_ext, m_acc, m_ticks, m_d, m_f, m_pend, m_pd, m_pf;

  logic              obs_tick, obs_mid, obs_bit;
  logic [PH_W-1:0]   obs_phase;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_ext = 0; m_acc = 0; m_ticks = 0;
    m_d = DEFAULT_DIV; m_f = 0; m_pend = 0; m_pd = 0; m_pf = 0;
  endtask

  // One clock cycle, entered and left at a negedge.
  task automatic step(input logic en, input logic clr, input logic ld,
                      input int unsigned di, input int unsigned df);
    int unsigned len, ph;
    logic et, em, eb;
    enable = en; clear = clr; div_load = ld;
    div_int = CNT_W'(di); div_frac = FRAC_W'(df);
    #1;
    len = m_d + 1 + m_ext;
    et  = en && !clr && (m_pos == len - 1);
    ph  = m_ticks % OVERSAMPLE;
    em  = et && (ph == OVERSAMPLE / 2 - 1);
    eb  = et && (ph == OVERSAMPLE - 1);
    obs_tick = sample_tick; obs_mid = mid_tick; obs_bit = bit_tick; obs_phase = phase;
    check_eq("sample_tick", sample_tick, et);
    check_eq("mid_tick", mid_tick, em);
    check_eq("bit_tick", bit_tick, eb);
    check_eq("phase", phase, ph);
    if (clr) begin
      m_pos = 0; m_ticks = 0; m_acc = 0; m_ext = 0;
    end else if (en) begin
      if (et) begin
        m_pos = 0;
        m_acc = m_acc + m_f;
        m_ext = (m_acc >= FRAC_MOD) ? 1 : 0;
        m_acc = m_acc % FRAC_MOD;
        m_ticks++;
      end else begin
        m_pos = (m_pos + 1) % CNT_MOD;
      end
    end
    if (ld && (!en || clr || et)) begin
      m_d = di; m_f = df; m_pend = 0;
    end else if (ld) begin
      m_pd = di; m_pf = df; m_pend = 1;
    end else if (m_pend != 0 && (clr || et)) begin
      m_d = m_pd; m_f = m_pf; m_pend = 0;
    end
    @(negedge clk);
  endtask

  // Entered at a negedge: pulse reset mid-cycle, check outputs, release.
  task automatic do_reset();
    enable = 1'b1; clear = 1'b0; div_load = 1'b0;
    #2 async_nreset = 1'b0;
    #1;
    check_eq("rst_tick", sample_tick, 0);
    check_eq("rst_mid", mid_tick, 0);
    check_eq("rst_bit", bit_tick, 0);
    check_eq("rst_phase", phase, 0);
    model_reset();
    @(negedge clk);
    async_nreset = 1'b1;
  endtask

  // Cycles up to and including the next sample tick, bounded.
  task automatic run_until_tick(input string tag, output int n);
    n = 0;
    do begin
      step(1'b1, 1'b0, 1'b0, 0, 0);
      n++;
    end while (!obs_tick && n < 300);
    check_eq({tag, "_seen"}, obs_tick, 1);
  endtask

  int   n, first, nt, mid_c, bit_c, total;
  logic r_en, r_clr, r_ld;

  initial begin
    model_reset();
    @(negedge clk);

    // Defaults from reset
    do_reset();
    first = 0; nt = 0; mid_c = 0; bit_c = 0;
    for (int c = 1; c <= 64; c++) begin
      step(1'b1, 1'b0, 1'b0, 0, 0);
      if (obs_tick) begin
        nt++;
        if (first == 0) first = c;
      end
      if (obs_mid && mid_c == 0) mid_c = c;
      if (obs_bit && bit_c == 0) bit_c = c;
    end
    check_eq("first_tick_cyc", first, 4);
    check_eq("ticks_in_64", nt, 16);
    check_eq("mid_cyc", mid_c, 32);
    check_eq("bit_cyc", bit_c, 64);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    check_eq("phase_after_bit", obs_phase, 0);

    // Fractional divisor D=9, F=8
    do_reset();
    step(1'b0, 1'b0, 1'b1, 9, 8);
    run_until_tick("frac_p1", n);
    check_eq("frac_first", n, 10);
    total = 0;
    for (int k = 2; k <= 33; k++) begin
      run_until_tick("frac_pk", n);
      check_eq("frac_period", n, (k % 2 == 0) ? 10 : 11);
      total += n;
    end
    check_eq("frac_span32", total, 336);

    // Load while running lands at the next boundary
    do_reset();
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b1, 7, 0);
    run_until_tick("ld_cur", n);
    check_eq("ld_cur_period", n + 2, 4);
    run_until_tick("ld_next", n);
    check_eq("ld_next_period", n, 8);

    // Second load overwrites the pending one
    do_reset();
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b1, 7, 0);
    step(1'b1, 1'b0, 1'b1, 5, 0);
    run_until_tick("ld2_cur", n);
    check_eq("ld2_cur_period", n + 3, 4);
    run_until_tick("ld2_next", n);
    check_eq("ld2_next_period", n, 6);

    // Load coinciding with a tick (active D=5 here, at cnt=0)
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b1, 2, 0);
    check_eq("coinc_tick", obs_tick, 1);
    run_until_tick("coinc_next", n);
    check_eq("coinc_next_period", n, 3);

    // Clear at cnt=2, phase=5
    do_reset();
    for (int k = 0; k < 5; k++) run_until_tick("clr_pre", n);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 0, 0);
    check_eq("clr_no_tick", obs_tick, 0);
    check_eq("clr_phase_before", obs_phase, 5);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    check_eq("clr_phase_after", obs_phase, 0);
    run_until_tick("clr_next", n);
    check_eq("clr_next_period", n + 1, 4);

    // Enable low for 5 cycles at cnt=2
    do_reset();
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    nt = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b0, 1'b0, 0, 0);
      if (obs_tick) nt++;
    end
    check_eq("idle_ticks", nt, 0);
    run_until_tick("idle_resume", n);
    check_eq("idle_resume_cycles", n, 2);

    // Async reset mid-period with a pending divisor
    do_reset();
    for (int k = 0; k < 3; k++) run_until_tick("arst_pre", n);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b1, 7, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    do_reset();
    run_until_tick("arst_p1", n);
    check_eq("arst_period1", n, 4);
    run_until_tick("arst_p2", n);
    check_eq("arst_period2", n, 4);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      r_en  = ($urandom_range(0, 99) < 85);
      r_clr = ($urandom_range(0, 99) < 3);
      r_ld  = ($urandom_range(0, 99) < 6);
      step(r_en, r_clr, r_ld, $urandom_range(0, 12), $urandom_range(0, FRAC_MOD - 1));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
